// File: rtl/jacobi_pkg.sv
// ============================================================================
// jacobi_pkg -- shared FSM state type and pivot-index width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package jacobi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Width of a pivot index; never below one bit even for a 2x2 matrix.
  function automatic int pair_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pair_gen.sv
// ============================================================================
// pair_gen -- cyclic row-order pivot pair (p,q), p<q, for one Jacobi sweep
// Rev 1.0
// ============================================================================
`default_nettype none

module pair_gen
  import jacobi_pkg::*;
#(
  parameter int N_STOCKS = 4,
  localparam int PW = pair_width(N_STOCKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          clear,
  output logic [PW-1:0] p,
  output logic [PW-1:0] q,
  output logic          last
);

  localparam logic [PW-1:0] LAST_P = PW'(N_STOCKS - 2);
  localparam logic [PW-1:0] LAST_Q = PW'(N_STOCKS - 1);

  assign last = (p == LAST_P) && (q == LAST_Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      q <= PW'(1);
    end else if (clear || (advance && last)) begin
      p <= '0;
      q <= PW'(1);
    end else if (advance) begin
      // End of a row: step to the next row, first column right of the diagonal.
      if (q == LAST_Q) begin
        p <= p + 1'b1;
        q <= p + PW'(2);
      end else begin
        q <= q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jacobi_sequencer.sv
// ============================================================================
// jacobi_sequencer -- sweeps Jacobi rotations over a covariance matrix until
// an external convergence flag is seen at a sweep boundary or the limit hits
// Rev 1.0
// ============================================================================
`default_nettype none

module jacobi_sequencer
  import jacobi_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRACT      = 8,
  parameter int N_STOCKS   = 4,
  parameter int MAX_SWEEPS = 8,
  localparam int PW = pair_width(N_STOCKS),
  localparam int SW = $clog2(MAX_SWEEPS + 1)
) (
  input  logic                                            clk_in,
  input  logic                                            rst_in,
  input  logic                                            start_in,
  input  logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_in,
  output logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_out,
  input  logic                                            conv_in,
  output logic                                            rot_valid_out,
  input  logic                                            rot_ready_in,
  output logic [PW-1:0]                                   rot_p_out,
  output logic [PW-1:0]                                   rot_q_out,
  input  logic                                            rot_done_in,
  input  logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] rot_matrix_in,
  output logic                                            busy_out,
  output logic                                            done_out,
  output logic                                            converged_out,
  output logic [SW-1:0]                                   sweeps_out
);

  if (N_STOCKS < 2 || MAX_SWEEPS < 1 || FRACT < 0 || FRACT >= WIDTH) begin : g_param_check
    $error("jacobi_sequencer: illegal parameter combination");
  end

  state_t state;
  logic   pair_clear;
  logic   pair_advance;
  logic   pair_last;

  assign pair_clear   = (state == S_IDLE) && start_in;
  assign pair_advance = (state == S_WAIT) && rot_done_in;

  pair_gen #(
    .N_STOCKS (N_STOCKS)
  ) u_pair_gen (
    .clk     (clk_in),
    .rst     (rst_in),
    .advance (pair_advance),
    .clear   (pair_clear),
    .p       (rot_p_out),
    .q       (rot_q_out),
    .last    (pair_last)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      matrix_out    <= '0;
      sweeps_out    <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      converged_out <= 1'b0;
      rot_valid_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            matrix_out    <= matrix_in;
            sweeps_out    <= '0;
            converged_out <= 1'b0;
            busy_out      <= 1'b1;
            state         <= S_CHECK;
          end
        end
        // Convergence is only trusted at a sweep boundary.
        S_CHECK: begin
          if (conv_in) begin
            converged_out <= 1'b1;
            done_out      <= 1'b1;
            state         <= S_DONE;
          end else if (sweeps_out == SW'(MAX_SWEEPS)) begin
            done_out <= 1'b1;
            state    <= S_DONE;
          end else begin
            rot_valid_out <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rot_ready_in) begin
            rot_valid_out <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rot_done_in) begin
            matrix_out <= rot_matrix_in;
            if (pair_last) begin
              sweeps_out <= sweeps_out + 1'b1;
              state      <= S_CHECK;
            end else begin
              rot_valid_out <= 1'b1;
              state         <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jacobi_sequencer.sv
// ============================================================================
// tb_jacobi_sequencer -- table-driven and randomized checks of the sequencer
// against a sweep-level reference model and a scripted rotation unit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jacobi_sequencer;
  import jacobi_pkg::*;

  localparam int WIDTH = 16;
  localparam int FRACT = 8;
  localparam int N     = 4;
  localparam int MAXS  = 2;
  localparam int PW    = $clog2(N);
  localparam int SW    = $clog2(MAXS + 1);
  localparam int R     = N * (N - 1) / 2;

  typedef logic signed [N-1:0][N-1:0][WIDTH-1:0] mat_t;

  typedef struct {
    bit diag;
    int conv_after;
    int rdly;
    int ddly;
    bit inj;
    bit exp_conv;
    int exp_sw;
    int exp_rots;
    int exp_lat;
  } vec_t;

  logic          clk_in = 1'b0;
  logic          rst_in, start_in, conv_in, rot_ready_in, rot_done_in;
  mat_t          matrix_in, matrix_out, rot_matrix_in;
  logic          rot_valid_out, busy_out, done_out, converged_out;
  logic [PW-1:0] rot_p_out, rot_q_out;
  logic [SW-1:0] sweeps_out;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_p[R];
  int exp_q[R];
  vec_t tbl[6];

  always #5 clk_in = ~clk_in;

  jacobi_sequencer #(
    .WIDTH(WIDTH), .FRACT(FRACT), .N_STOCKS(N), .MAX_SWEEPS(MAXS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .matrix_in(matrix_in), .matrix_out(matrix_out), .conv_in(conv_in),
    .rot_valid_out(rot_valid_out), .rot_ready_in(rot_ready_in),
    .rot_p_out(rot_p_out), .rot_q_out(rot_q_out), .rot_done_in(rot_done_in),
    .rot_matrix_in(rot_matrix_in), .busy_out(busy_out), .done_out(done_out),
    .converged_out(converged_out), .sweeps_out(sweeps_out)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_mat(input string name, input mat_t act, input mat_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = WIDTH'($urandom);
    return m;
  endfunction

  function automatic mat_t diag_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = (i == j) ? WIDTH'(16'h0100) : '0;
    return m;
  endfunction

  // Sweep-level model: conv_in goes high once conv_after rotations are done,
  // and is only honoured at the first sweep boundary reached after that.
  function automatic void model(input int conv_after, input int rdly, input int ddly,
                                output bit c, output int sw, output int rots, output int lat);
    int s;
    s = (conv_after <= 0) ? 0 : (conv_after + R - 1) / R;
    if (s <= MAXS) begin c = 1'b1; sw = s; end
    else           begin c = 1'b0; sw = MAXS; end
    rots = sw * R;
    lat  = 2 + sw * (2 * R + 1) + rots * (rdly + ddly);
  endfunction

  task automatic run_job(input mat_t m, input int conv_after, input int rdly, input int ddly,
                         input bit inj, output int nrot, output int lat, output bit timeout);
    mat_t          held, rm;
    logic [PW-1:0] hp, hq;
    bit            finished;
    finished = 1'b0;
    nrot = 0; lat = 0; timeout = 1'b0;
    matrix_in = m; start_in = 1'b1; conv_in = (conv_after <= 0);
    @(negedge clk_in); lat = 1;
    start_in = 1'b0; matrix_in = rand_mat();
    check_mat("latch_matrix", matrix_out, m);
    check("busy_after_start", busy_out, 1);
    while (!finished && lat < 2000) begin
      conv_in = (nrot >= conv_after);
      if (done_out) begin
        finished = 1'b1;
      end else if (rot_valid_out) begin
        hp = rot_p_out; hq = rot_q_out; held = matrix_out;
        check("pair_p", hp, exp_p[nrot % R]);
        check("pair_q", hq, exp_q[nrot % R]);
        for (int i = 0; i < rdly; i++) begin
          if (inj && i == 0) begin
            start_in = 1'b1; rot_done_in = 1'b1; rot_matrix_in = rand_mat();
          end
          @(negedge clk_in); lat++;
          start_in = 1'b0; rot_done_in = 1'b0;
          check("valid_held", rot_valid_out, 1);
          check("p_held", rot_p_out, hp);
          check("q_held", rot_q_out, hq);
          check_mat("matrix_held_issue", matrix_out, held);
        end
        rot_ready_in = 1'b1;
        @(negedge clk_in); lat++;
        rot_ready_in = 1'b0;
        check("valid_drop", rot_valid_out, 0);
        for (int i = 0; i < ddly; i++) begin
          @(negedge clk_in); lat++;
          check("pair_held_wait", {rot_p_out, rot_q_out}, {hp, hq});
          check_mat("matrix_held_wait", matrix_out, held);
        end
        rm = rand_mat(); rot_matrix_in = rm; rot_done_in = 1'b1;
        @(negedge clk_in); lat++;
        rot_done_in = 1'b0;
        check_mat("rot_load", matrix_out, rm);
        nrot++;
      end else begin
        @(negedge clk_in); lat++;
      end
    end
    timeout = !finished;
    conv_in = 1'b0;
  endtask

  task automatic apply(input string tag, input mat_t m, input int conv_after, input int rdly,
                       input int ddly, input bit inj, input bit exp_conv, input int exp_sw,
                       input int exp_rots, input int exp_lat);
    int nrot, lat;
    bit timeout;
    logic c_fin;
    logic [SW-1:0] s_fin;
    run_job(m, conv_after, rdly, ddly, inj, nrot, lat, timeout);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_converged"}, converged_out, exp_conv);
    check({tag, "_sweeps"}, sweeps_out, exp_sw);
    check({tag, "_rotations"}, nrot, exp_rots);
    check({tag, "_latency"}, lat, exp_lat);
    c_fin = converged_out; s_fin = sweeps_out;
    @(negedge clk_in);
    check({tag, "_done_pulse"}, done_out, 0);
    check({tag, "_idle_busy"}, busy_out, 0);
    repeat (3) @(negedge clk_in);
    check({tag, "_conv_hold"}, converged_out, c_fin);
    check({tag, "_sweeps_hold"}, sweeps_out, s_fin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit mc;
    int msw, mrots, mlat;
    mat_t m;

    idx = 0;
    for (int p = 0; p < N - 1; p++)
      for (int q = p + 1; q < N; q++) begin
        exp_p[idx] = p; exp_q[idx] = q; idx++;
      end

    //           diag conv rdly ddly inj  conv sw rots lat
    tbl[0] = '{1'b1,  0,   0,   0, 1'b0, 1'b1, 0,  0,  2};
    tbl[1] = '{1'b0, 99,   0,   0, 1'b0, 1'b0, 2, 12, 28};
    tbl[2] = '{1'b0,  2,   0,   0, 1'b0, 1'b1, 1,  6, 15};
    tbl[3] = '{1'b0, 99,   3,   0, 1'b0, 1'b0, 2, 12, 64};
    tbl[4] = '{1'b0,  6,   1,   2, 1'b1, 1'b1, 1,  6, 33};
    tbl[5] = '{1'b0,  7,   0,   1, 1'b0, 1'b1, 2, 12, 40};

    rst_in = 1'b1; start_in = 1'b0; conv_in = 1'b0;
    rot_ready_in = 1'b0; rot_done_in = 1'b0;
    matrix_in = '0; rot_matrix_in = '0;
    #1;
    check("rst_busy", busy_out, 0);
    check("rst_valid", rot_valid_out, 0);
    check("rst_done", done_out, 0);
    check("rst_pair", {rot_p_out, rot_q_out}, {PW'(0), PW'(1)});
    check_mat("rst_matrix", matrix_out, '0);
    @(negedge clk_in); @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    foreach (tbl[k]) begin
      m = tbl[k].diag ? diag_mat() : rand_mat();
      apply($sformatf("vec%0d", k), m, tbl[k].conv_after, tbl[k].rdly, tbl[k].ddly,
            tbl[k].inj, tbl[k].exp_conv, tbl[k].exp_sw, tbl[k].exp_rots, tbl[k].exp_lat);
    end

    // Asynchronous reset while a rotation is outstanding.
    matrix_in = rand_mat(); start_in = 1'b1;
    @(negedge clk_in); start_in = 1'b0;
    for (int i = 0; i < 20 && !rot_valid_out; i++) @(negedge clk_in);
    check("rst_reach_issue", rot_valid_out, 1);
    rot_ready_in = 1'b1;
    @(negedge clk_in); rot_ready_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    check_mat("async_rst_matrix", matrix_out, '0);
    check("async_rst_busy", busy_out, 0);
    check("async_rst_valid", rot_valid_out, 0);
    check("async_rst_sweeps", sweeps_out, 0);
    check("async_rst_pair", {rot_p_out, rot_q_out}, {PW'(0), PW'(1)});
    @(negedge clk_in); rst_in = 1'b0;
    rot_matrix_in = rand_mat(); rot_done_in = 1'b1;
    @(negedge clk_in); rot_done_in = 1'b0;
    check_mat("late_done_matrix", matrix_out, '0);
    check("late_done_busy", busy_out, 0);
    apply("post_rst", rand_mat(), 99, 0, 0, 1'b0, 1'b0, 2, 12, 28);

    for (int k = 0; k < 8; k++) begin
      int ca, rd, dd;
      ca = $urandom_range(0, 14);
      rd = $urandom_range(0, 2);
      dd = $urandom_range(0, 2);
      model(ca, rd, dd, mc, msw, mrots, mlat);
      apply($sformatf("rnd%0d", k), rand_mat(), ca, rd, dd, rd > 0 && $urandom_range(0, 1) == 1,
            mc, msw, mrots, mlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jacobi_sequencer.md
JACOBI_SEQUENCER -- requirements
Module: jacobi_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed fixed-point element width.
REQ-002 SHALL have parameter FRACT, default 8, fractional bits (informational, passed to checker).
REQ-003 SHALL have parameter N_STOCKS, default 4, matrix dimension (>=2).
REQ-004 SHALL have parameter MAX_SWEEPS, default 8, sweep limit (>=1).
REQ-005 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start_in  input  1  begin diagonalisation of matrix_in.
REQ-008 SHALL have port matrix_in  input  N_STOCKS x N_STOCKS x WIDTH signed  initial covariance matrix.
REQ-009 SHALL have port matrix_out  output  N_STOCKS x N_STOCKS x WIDTH signed  working matrix register.
REQ-010 SHALL have port conv_in  input  1  combinational off-diagonal-converged flag computed externally from matrix_out.
REQ-011 SHALL have port rot_valid_out  output  1  rotation request.
REQ-012 SHALL have port rot_ready_in  input  1  rotation unit accepts request.
REQ-013 SHALL have ports rot_p_out, rot_q_out  output  $clog2(N_STOCKS) each  pivot pair, p<q.
REQ-014 SHALL have port rot_done_in  input  1  rotated matrix valid on rot_matrix_in.
REQ-015 SHALL have port rot_matrix_in  input  N_STOCKS x N_STOCKS x WIDTH signed  rotated matrix.
REQ-016 SHALL have ports busy_out 1, done_out 1, converged_out 1, sweeps_out $clog2(MAX_SWEEPS+1), all outputs.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, ISSUE, WAIT, DONE.
REQ-018 IDLE: on start_in, SHALL latch matrix_in into matrix_out, clear sweep count, set (p,q)=(0,1), clear converged_out, go CHECK.
REQ-019 CHECK (one cycle): conv_in=1 -> DONE with converged_out=1; else sweep count==MAX_SWEEPS -> DONE with converged_out=0; else -> ISSUE.
REQ-020 ISSUE: rot_valid_out=1; on rot_valid_out&&rot_ready_in SHALL go WAIT.
REQ-021 rot_p_out, rot_q_out, matrix_out SHALL be stable while rot_valid_out is high and throughout WAIT.
REQ-022 WAIT: on rot_done_in SHALL load rot_matrix_in into matrix_out and advance pair in cyclic row order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
REQ-023 After the pair (N-2,N-1) completes, SHALL increment sweep count, wrap to (0,1), go CHECK; otherwise go ISSUE.
REQ-024 conv_in SHALL be sampled only in CHECK (sweep boundaries); mid-sweep assertion ignored.
REQ-025 DONE: done_out SHALL pulse high exactly one cycle, then return to IDLE.
REQ-026 converged_out and sweeps_out SHALL hold their final values until the next accepted start_in.
REQ-027 busy_out SHALL be high in every state except IDLE.
REQ-028 start_in outside IDLE, rot_ready_in outside ISSUE, rot_done_in outside WAIT SHALL be ignored.
REQ-029 Minimum latency per rotation: 2 cycles (ISSUE accept, WAIT done next cycle); one sweep = N(N-1)/2 rotations plus one CHECK cycle.

Reset
REQ-030 rst_in SHALL asynchronously force IDLE, zero matrix_out, (p,q)=(0,1), sweep count 0, and all outputs low/zero.
REQ-031 Reset mid-operation SHALL abandon the outstanding rotation; a later rot_done_in SHALL be ignored in IDLE.

Structure
REQ-032 Shared package jacobi_pkg SHALL hold the state enum and a pair-index width constant/function.
REQ-033 Pair advance/wrap logic SHALL be one sub-module, pair_gen (inputs advance, clear; outputs p, q, last).

Verification
REQ-034 Diagonal input (diag 0x0100, off-diag 0), conv_in=1: start -> done_out 2 cycles later, converged_out=1, sweeps_out=0, rot_valid_out never high.
REQ-035 MAX_SWEEPS=2, stub always ready, done 1 cycle after accept, conv_in=0: 12 rotations in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) x2 -> converged_out=0, sweeps_out=2.
REQ-036 rot_ready_in delayed 3 cycles -> rot_valid_out held 3 cycles, p/q/matrix_out unchanged.
REQ-037 conv_in raised after 2nd rotation of sweep 1 -> remaining 4 rotations issued, then converged_out=1, sweeps_out=1.
REQ-038 rst_in asserted in WAIT -> outputs zero same cycle without clock edge; late rot_done_in ignored; next start runs normally.
REQ-039 start_in pulsed while busy and rot_done_in pulsed in ISSUE -> no state, pair or matrix change.
